// File: rtl/event_tx_fifo_pkg.sv
// Shared types for the event transmit path: the packed spike event, the
// output handshake states and the malformed-event test.
package event_tx_fifo_pkg;

  localparam int unsigned IN_CHANNELS = 2;
  localparam int unsigned COORD_BITS  = 8;
  localparam int unsigned TS_BITS     = 8;
  localparam int unsigned EVENT_W     = TS_BITS + 2*COORD_BITS + IN_CHANNELS;

  typedef struct packed {
    logic [TS_BITS-1:0]     timestep;
    logic [COORD_BITS-1:0]  x;
    logic [COORD_BITS-1:0]  y;
    logic [IN_CHANNELS-1:0] spikes;
  } event_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_RELEASE
  } tx_state_t;

  // An event is unusable downstream if it lies outside the image or carries no spikes.
  function automatic logic event_malformed(event_t ev, int unsigned width, int unsigned height);
    return (32'(ev.x) >= width) || (32'(ev.y) >= height) || (ev.spikes == '0);
  endfunction

endpackage

// File: rtl/event_sync_fifo.sv
// Synchronous event FIFO: storage, wrap-bit pointers and occupancy.
// Pushes while full and pops while empty are ignored.
module event_sync_fifo
  import event_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  event_t                 wdata,
  output event_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  event_t      mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/event_tx_fifo.sv
// Transmit end of the event_valid/event_ack protocol. Filters malformed
// events, queues the rest and presents them one at a time on a held-stable
// output register. Defining EVENT_TX_DROP_CNT_EN adds a saturating
// drop_count port counting filtered events.
module event_tx_fifo
  import event_tx_fifo_pkg::*;
#(
  parameter int unsigned IMG_WIDTH     = 8,
  parameter int unsigned IMG_HEIGHT    = 8,
`ifdef EVENT_TX_DROP_CNT_EN
  parameter int unsigned DROP_CNT_BITS = 16,
`endif
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  event_t                      in_event,
  output event_t                      event_out,
  output logic                        event_valid,
  input  logic                        event_ack,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`ifdef EVENT_TX_DROP_CNT_EN
  output logic [DROP_CNT_BITS-1:0]    drop_count,
`endif
  output logic                        busy
);

  tx_state_t state;
  tx_state_t state_next;
  event_t    head;
  logic      full;
  logic      empty;
  logic      accept;
  logic      malformed;
  logic      push;
  logic      pop;
  logic      load_out;
  logic      clear_valid;

  assign in_ready  = !full && !rst;
  assign accept    = in_valid && in_ready;
  assign malformed = event_malformed(in_event, IMG_WIDTH, IMG_HEIGHT);
  assign push      = accept && !malformed;
  assign busy      = !empty || (state != IDLE);

  event_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_event),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Output state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake strobes; a held ack releases only one event.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    load_out    = 1'b0;
    clear_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          load_out   = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (event_ack) begin
          clear_valid = 1'b1;
          state_next  = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!event_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Presented event register; only loaded from IDLE, so stable while valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_out   <= '0;
      event_valid <= 1'b0;
    end else if (load_out) begin
      event_out   <= head;
      event_valid <= 1'b1;
    end else if (clear_valid) begin
      event_valid <= 1'b0;
    end
  end

`ifdef EVENT_TX_DROP_CNT_EN
  // Saturating count of accepted-but-filtered events.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (accept && malformed && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule
